// File: rtl/sram22_ctrl_pkg.sv
// Shared types and sizes for controllers that sit in front of the SRAM22 macro.
package sram22_ctrl_pkg;

  localparam int SRAM_DEPTH  = 128;
  localparam int SRAM_ADDR_W = $clog2(SRAM_DEPTH);
  localparam int SRAM_DATA_W = 32;

  // Largest supported requester count; sizes the port index in the read tag.
  localparam int MAX_PORTS  = 4;
  localparam int PORT_IDX_W = $clog2(MAX_PORTS);

  typedef struct packed {
    logic                   we;
    logic [SRAM_ADDR_W-1:0] addr;
    logic [SRAM_DATA_W-1:0] wdata;
  } sram_req_t;

  typedef struct packed {
    logic                  valid;
    logic [PORT_IDX_W-1:0] port;
  } rd_tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first eligible requester after the
// last granted one. The pointer moves only on cycles where update is asserted.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] eligible,
  input  logic         update,
  output logic [N-1:0] grant
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] idx;
  logic          found;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    for (int off = 1; off <= N; off++) begin
      idx = IW'((int'(ptr_q) + off) % N);
      if (!found && eligible[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (update) begin
      for (int i = 0; i < N; i++) begin
        if (grant[i]) ptr_d = IW'(i);
      end
    end
  end

  // Reset to the last port so port 0 is searched first.
  always_ff @(posedge clk) begin
    if (!rst_n) ptr_q <= IW'(N - 1);
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/sram22_rr_arbiter.sv
// Shares one SRAM22 macro between NUM_PORTS requesters with round-robin grants,
// one outstanding read per port and a per-port buffered read response.
module sram22_rr_arbiter
  import sram22_ctrl_pkg::*;
#(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 32
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_PORTS-1:0]            req_valid,
  output logic [NUM_PORTS-1:0]            req_ready,
  input  logic [NUM_PORTS-1:0]            req_we,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_PORTS-1:0]            rsp_valid,
  input  logic [NUM_PORTS-1:0]            rsp_ready,
  output logic [NUM_PORTS*DATA_WIDTH-1:0] rsp_rdata,
  output logic                            sram_we,
  output logic                            sram_wmask,
  output logic [ADDR_WIDTH-1:0]           sram_addr,
  output logic [DATA_WIDTH-1:0]           sram_din,
  input  logic [DATA_WIDTH-1:0]           sram_dout
);

  logic [NUM_PORTS-1:0]  grant, eligible, rsp_hs, read_grant;
  logic [NUM_PORTS-1:0]  slot_busy_q, slot_busy_d;
  logic [NUM_PORTS-1:0]  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q [NUM_PORTS];
  logic [DATA_WIDTH-1:0] rsp_rdata_d [NUM_PORTS];
  rd_tag_t               tag_q, tag_d;
  sram_req_t             sel;
  logic [PORT_IDX_W-1:0] gnt_idx;

  // A handshake frees the slot in the same cycle, so a port can re-read immediately.
  always_comb begin
    rsp_hs   = rsp_valid_q & rsp_ready;
    eligible = req_valid & (req_we | ~slot_busy_q | rsp_hs);
  end

  rr_arbiter #(.N(NUM_PORTS)) u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .eligible (eligible),
    .update   (|grant),
    .grant    (grant)
  );

  always_comb begin
    sel     = '0;
    gnt_idx = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant[i]) begin
        sel.we    = req_we[i];
        sel.addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel.wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        gnt_idx   = PORT_IDX_W'(i);
      end
    end
  end

  assign req_ready  = grant;
  assign read_grant = grant & ~req_we;
  assign sram_we    = sel.we;
  assign sram_wmask = sel.we;
  assign sram_addr  = sel.addr;
  assign sram_din   = sel.wdata;

  // The tag is only valid after a read grant, so post-write dout is never captured.
  always_comb begin
    tag_d.valid = |read_grant;
    tag_d.port  = gnt_idx;
    slot_busy_d = (slot_busy_q & ~rsp_hs) | read_grant;
    rsp_valid_d = rsp_valid_q & ~rsp_hs;
    rsp_rdata_d = rsp_rdata_q;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (tag_q.valid && tag_q.port == PORT_IDX_W'(i)) begin
        rsp_valid_d[i] = 1'b1;
        rsp_rdata_d[i] = sram_dout;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_busy_q <= '0;
      rsp_valid_q <= '0;
      tag_q       <= '0;
      for (int i = 0; i < NUM_PORTS; i++) rsp_rdata_q[i] <= '0;
    end else begin
      slot_busy_q <= slot_busy_d;
      rsp_valid_q <= rsp_valid_d;
      tag_q       <= tag_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign rsp_valid = rsp_valid_q;

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_rdata
    assign rsp_rdata[g*DATA_WIDTH +: DATA_WIDTH] = rsp_rdata_q[g];
  end

endmodule

// File: tb/tb_sram22_rr_arbiter.sv
// Bench for sram22_rr_arbiter: a fixed vector table, hand-written corner sequences
// and random traffic, all checked against a transaction-level reference model.
module tb_sram22_rr_arbiter;

  localparam int NP = 2;
  localparam int AW = 7;
  localparam int DW = 32;
  localparam logic [DW-1:0] POISON = 32'hBAD0_BAD0;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NP-1:0]     req_valid, req_ready, req_we, rsp_valid, rsp_ready;
  logic [NP*AW-1:0]  req_addr;
  logic [NP*DW-1:0]  req_wdata, rsp_rdata;
  logic              sram_we, sram_wmask;
  logic [AW-1:0]     sram_addr;
  logic [DW-1:0]     sram_din, sram_dout;

  always #5 clk = ~clk;

  sram22_rr_arbiter #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .sram_we    (sram_we),
    .sram_wmask (sram_wmask),
    .sram_addr  (sram_addr),
    .sram_din   (sram_din),
    .sram_dout  (sram_dout)
  );

  // Macro stand-in: registered read, poison on dout the cycle after a write.
  logic [DW-1:0] mac_mem [128];
  logic          mac_init = 1'b0;
  always @(posedge clk) begin
    if (!mac_init) begin
      for (int i = 0; i < 128; i++) mac_mem[i] <= '0;
      mac_init  <= 1'b1;
      sram_dout <= '0;
    end else if (sram_we) begin
      mac_mem[sram_addr] <= sram_din;
      sram_dout          <= POISON;
    end else begin
      sram_dout <= mac_mem[sram_addr];
    end
  end

  int errors = 0;
  int checks = 0;
  longint cyc = 0;

  // Reference model: memory image, pending responses with due cycle, RR owner.
  typedef struct {
    int          port;
    logic [31:0] data;
    longint      due;
  } pend_t;

  pend_t       pq[$];
  logic [31:0] m_mem [128];
  logic [31:0] m_last [NP];
  int          m_ptr;
  int          m_g;
  logic [NP-1:0] m_hs;

  logic          d_rst_n;
  logic [NP-1:0] d_valid, d_we, d_rr;
  logic [AW-1:0] d_addr [NP];
  logic [31:0]   d_wdata [NP];

  typedef struct {
    logic        rst_n;
    logic [1:0]  valid, we;
    logic [6:0]  a0, a1;
    logic [31:0] wd0, wd1;
    logic [1:0]  e_ready;
    logic        e_we;
    logic [6:0]  e_addr;
    logic [1:0]  e_rv;
    logic [31:0] e_rd0;
  } vec_t;

  vec_t tbl [16];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  task automatic setIdle();
    d_rst_n = 1'b1;
    d_valid = '0;
    d_we    = '0;
    d_rr    = '1;
    for (int p = 0; p < NP; p++) begin
      d_addr[p]  = '0;
      d_wdata[p] = '0;
    end
  endtask

  // Drive the current request set, then compare every output with the model.
  task automatic applyStimulus();
    logic [NP-1:0] busy, vis, exp_ready;
    logic          e_we;
    logic [AW-1:0] e_addr;
    logic [31:0]   e_din;
    rst_n     = d_rst_n;
    req_valid = d_valid;
    req_we    = d_we;
    rsp_ready = d_rr;
    for (int p = 0; p < NP; p++) begin
      req_addr[p*AW +: AW]  = d_addr[p];
      req_wdata[p*DW +: DW] = d_wdata[p];
    end
    #1;
    busy = '0;
    vis  = '0;
    for (int p = 0; p < NP; p++) begin
      foreach (pq[k]) begin
        if (pq[k].port == p) begin
          busy[p] = 1'b1;
          if (pq[k].due <= cyc) begin
            vis[p]    = 1'b1;
            m_last[p] = pq[k].data;
          end
        end
      end
    end
    m_hs = vis & d_rr;
    m_g  = -1;
    for (int off = 1; off <= NP; off++) begin
      int idx;
      idx = (m_ptr + off) % NP;
      if (m_g < 0 && d_valid[idx] && (d_we[idx] || !busy[idx] || m_hs[idx])) m_g = idx;
    end
    exp_ready = '0;
    e_we      = 1'b0;
    e_addr    = '0;
    e_din     = '0;
    if (m_g >= 0) begin
      exp_ready[m_g] = 1'b1;
      e_we   = d_we[m_g];
      e_addr = d_addr[m_g];
      e_din  = d_we[m_g] ? d_wdata[m_g] : 32'h0;
    end
    checkOutput("req_ready", req_ready, exp_ready);
    checkOutput("sram_we", sram_we, e_we);
    checkOutput("sram_wmask", sram_wmask, e_we);
    checkOutput("sram_addr", sram_addr, e_addr);
    if (e_we) checkOutput("sram_din", sram_din, e_din);
    checkOutput("rsp_valid", rsp_valid, vis);
    for (int p = 0; p < NP; p++)
      checkOutput($sformatf("rsp_rdata%0d", p), rsp_rdata[p*DW +: DW], m_last[p]);
    checkOutput("rdata_known", $isunknown(rsp_rdata), 0);
  endtask

  // Commit the cycle to the model, then step past the next clock edge.
  task automatic advanceCycle();
    for (int p = 0; p < NP; p++) begin
      if (m_hs[p]) begin
        for (int k = 0; k < pq.size(); k++) begin
          if (pq[k].port == p) begin
            pq.delete(k);
            break;
          end
        end
      end
    end
    if (m_g >= 0 && d_we[m_g]) m_mem[d_addr[m_g]] = d_wdata[m_g];
    if (!d_rst_n) begin
      pq.delete();
      m_ptr = NP - 1;
      for (int p = 0; p < NP; p++) m_last[p] = '0;
    end else if (m_g >= 0) begin
      if (!d_we[m_g]) pq.push_back('{port: m_g, data: m_mem[d_addr[m_g]], due: cyc + 2});
      m_ptr = m_g;
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic stepCycle();
    applyStimulus();
    advanceCycle();
  endtask

  initial begin
    int cnt0, cnt1;
    setIdle();
    d_rst_n = 1'b0;
    rst_n = 1'b0; req_valid = '0; req_we = '0; rsp_ready = '1; req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 128; i++) m_mem[i] = '0;
    for (int p = 0; p < NP; p++) m_last[p] = '0;
    m_ptr = NP - 1;
    cyc = 0;

    //              rst valid   we    a0    a1    wd0           wd1     ready  we    addr  rv     rd0
    tbl[0]  = '{1'b1, 2'b01, 2'b01, 7'd5,  7'd0,  32'hDEADBEEF, 32'd0,  2'b01, 1'b1, 7'd5,  2'b00, 32'h0};
    tbl[1]  = '{1'b1, 2'b01, 2'b00, 7'd5,  7'd0,  32'd0,        32'd0,  2'b01, 1'b0, 7'd5,  2'b00, 32'h0};
    tbl[2]  = '{1'b1, 2'b00, 2'b00, 7'd0,  7'd0,  32'd0,        32'd0,  2'b00, 1'b0, 7'd0,  2'b00, 32'h0};
    tbl[3]  = '{1'b1, 2'b00, 2'b00, 7'd0,  7'd0,  32'd0,        32'd0,  2'b00, 1'b0, 7'd0,  2'b01, 32'hDEADBEEF};
    tbl[4]  = '{1'b1, 2'b00, 2'b00, 7'd0,  7'd0,  32'd0,        32'd0,  2'b00, 1'b0, 7'd0,  2'b00, 32'hDEADBEEF};
    tbl[5]  = '{1'b0, 2'b00, 2'b00, 7'd0,  7'd0,  32'd0,        32'd0,  2'b00, 1'b0, 7'd0,  2'b00, 32'hDEADBEEF};
    tbl[6]  = '{1'b1, 2'b11, 2'b11, 7'd10, 7'd20, 32'd100,      32'd200, 2'b01, 1'b1, 7'd10, 2'b00, 32'h0};
    tbl[7]  = '{1'b1, 2'b11, 2'b11, 7'd10, 7'd20, 32'd100,      32'd200, 2'b10, 1'b1, 7'd20, 2'b00, 32'h0};
    tbl[8]  = '{1'b1, 2'b11, 2'b11, 7'd10, 7'd20, 32'd100,      32'd200, 2'b01, 1'b1, 7'd10, 2'b00, 32'h0};
    tbl[9]  = '{1'b1, 2'b11, 2'b11, 7'd10, 7'd20, 32'd100,      32'd200, 2'b10, 1'b1, 7'd20, 2'b00, 32'h0};
    for (int i = 10; i < 15; i++)
      tbl[i] = '{1'b1, 2'b00, 2'b00, 7'd0, 7'd0, 32'd0, 32'd0, 2'b00, 1'b0, 7'd0, 2'b00, 32'h0};
    tbl[15] = '{1'b1, 2'b11, 2'b11, 7'd10, 7'd20, 32'd100,      32'd200, 2'b01, 1'b1, 7'd10, 2'b00, 32'h0};

    $display("[TB] table vectors");
    cnt0 = 0;
    cnt1 = 0;
    for (int i = 0; i < 16; i++) begin
      setIdle();
      d_rst_n    = tbl[i].rst_n;
      d_valid    = tbl[i].valid;
      d_we       = tbl[i].we;
      d_addr[0]  = tbl[i].a0;
      d_addr[1]  = tbl[i].a1;
      d_wdata[0] = tbl[i].wd0;
      d_wdata[1] = tbl[i].wd1;
      applyStimulus();
      checkOutput($sformatf("tbl%0d_ready", i), req_ready, tbl[i].e_ready);
      checkOutput($sformatf("tbl%0d_we", i), sram_we, tbl[i].e_we);
      checkOutput($sformatf("tbl%0d_addr", i), sram_addr, tbl[i].e_addr);
      checkOutput($sformatf("tbl%0d_rv", i), rsp_valid, tbl[i].e_rv);
      checkOutput($sformatf("tbl%0d_rd0", i), rsp_rdata[31:0], tbl[i].e_rd0);
      if (i >= 6 && i <= 9) begin
        cnt0 += int'(req_ready[0]);
        cnt1 += int'(req_ready[1]);
      end
      advanceCycle();
    end
    checkOutput("share_p0", cnt0, 2);
    checkOutput("share_p1", cnt1, 2);

    $display("[TB] held response blocks only its own port");
    setIdle();
    d_valid = 2'b10; d_we = 2'b10; d_addr[1] = 7'd9; d_wdata[1] = 32'h11;
    stepCycle();
    d_we = 2'b00; d_rr = 2'b01;
    stepCycle();
    for (int k = 0; k < 12; k++) begin
      d_valid = 2'b11; d_we = 2'b01;
      d_addr[0] = 7'(7'h40 + k); d_wdata[0] = $urandom;
      applyStimulus();
      checkOutput("hold_p0_grant", req_ready[0], 1'b1);
      if (k >= 1) begin
        checkOutput("hold_rv1", rsp_valid[1], 1'b1);
        checkOutput("hold_rd1", rsp_rdata[63:32], 32'h11);
        checkOutput("hold_no_grant1", req_ready[1], 1'b0);
      end
      advanceCycle();
    end
    d_rr = 2'b11;
    applyStimulus();
    checkOutput("release_grant1", req_ready[1], 1'b1);
    advanceCycle();
    setIdle();
    repeat (3) stepCycle();

    $display("[TB] read then write same address");
    setIdle();
    d_valid = 2'b01; d_we = 2'b01; d_addr[0] = 7'd3; d_wdata[0] = 32'hA;
    stepCycle();
    d_we = 2'b00;
    stepCycle();
    setIdle();
    d_valid = 2'b10; d_we = 2'b10; d_addr[1] = 7'd3; d_wdata[1] = 32'hB;
    applyStimulus();
    checkOutput("rw_grant1", req_ready, 2'b10);
    advanceCycle();
    setIdle();
    applyStimulus();
    checkOutput("rw_old_rv", rsp_valid[0], 1'b1);
    checkOutput("rw_old_data", rsp_rdata[31:0], 32'hA);
    advanceCycle();
    d_valid = 2'b01; d_addr[0] = 7'd3;
    stepCycle();
    setIdle();
    stepCycle();
    applyStimulus();
    checkOutput("rw_new_data", rsp_rdata[31:0], 32'hB);
    advanceCycle();

    $display("[TB] reset with a read in flight");
    setIdle();
    d_valid = 2'b01; d_addr[0] = 7'd5;
    stepCycle();
    setIdle();
    d_rst_n = 1'b0;
    stepCycle();
    setIdle();
    for (int k = 0; k < 4; k++) begin
      applyStimulus();
      checkOutput("rst_rv", rsp_valid, 2'b00);
      advanceCycle();
    end
    d_valid = 2'b11; d_we = 2'b11; d_addr[0] = 7'd30; d_addr[1] = 7'd31;
    applyStimulus();
    checkOutput("rst_first_grant", req_ready, 2'b01);
    advanceCycle();

    $display("[TB] random traffic");
    setIdle();
    for (int n = 0; n < 400; n++) begin
      for (int p = 0; p < NP; p++) begin
        if (!d_valid[p] && $urandom_range(0, 2) != 0) begin
          d_valid[p] = 1'b1;
          d_we[p]    = 1'($urandom_range(0, 1));
          d_addr[p]  = 7'($urandom_range(0, 15));
          d_wdata[p] = $urandom;
        end
      end
      d_rr = 2'($urandom_range(0, 3));
      applyStimulus();
      advanceCycle();
      if (m_g >= 0) d_valid[m_g] = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
